// File: rtl/simple_risc_pkg.sv
// simple_risc_pkg: shared types and constants for the Simple RISC memory-access stage
package simple_risc_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [0:0] {MA_IDLE, MA_MEM_WAIT} ma_state_e;

    typedef struct packed {
        logic                  isWb;
        logic                  isCall;
        logic                  isLd;
        logic [REG_ADDR_W-1:0] Rd;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     ldResult;
        logic [DATA_W-1:0]     pc;
    } ma_rw_t;
endpackage

// File: rtl/ma_rw_latch.sv
// ma_rw_latch: MA/RW pipeline register with load-enable, separate load-data capture and valid gating
module ma_rw_latch
    import simple_risc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  ma_rw_t            i_fields,
    input  logic              i_ld_we,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_fire,
    input  logic              i_kill_wb,
    output logic              o_valid,
    output ma_rw_t            o_bundle
);
    ma_rw_t r_q;
    logic   r_valid;

    // ldResult is owned by i_ld_we only, so stores and ALU ops leave it untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_fire;
            if (i_load) r_q <= i_fields;
            r_q.ldResult <= i_ld_we ? i_ld_data : r_q.ldResult;
            if (i_kill_wb) r_q.isWb <= 1'b0;
        end
    end

    always_comb begin
        o_bundle        = r_q;
        o_bundle.isWb   = r_q.isWb & r_valid;
        o_bundle.isCall = r_q.isCall & r_valid;
        o_bundle.isLd   = r_q.isLd & r_valid;
    end

    assign o_valid = r_valid;
endmodule

// File: rtl/ma_stage.sv
// ma_stage: memory-access stage with req/ack data bus, wait timeout and RW handoff.
// Optional MA_MISALIGN_TRAP_EN traps loads/stores with a non-word-aligned address.
module ma_stage
    import simple_risc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_isLd,
    input  logic                  ex_isSt,
    input  logic                  ex_isWb,
    input  logic                  ex_isCall,
    input  logic [REG_ADDR_W-1:0] ex_Rd,
    input  logic [DATA_W-1:0]     ex_aluResult,
    input  logic [DATA_W-1:0]     ex_op2,
    input  logic [DATA_W-1:0]     ex_pc,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  isWb,
    output logic                  isCall,
    output logic                  isLd,
    output logic [REG_ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0]     aluResult,
    output logic [DATA_W-1:0]     ldResult,
    output logic [DATA_W-1:0]     pc_current,
    output logic                  rw_valid,
    output logic                  mem_err
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    ma_state_e         r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_alive, r_we, r_err;
    logic [DATA_W-1:0] r_addr, r_wdata;
    logic              w_acc, w_mem, w_mis, w_to, w_fire, w_kill, w_ld_we;
    ma_rw_t            w_fields, w_bundle;

    assign w_acc = ex_valid & r_alive & (r_state == MA_IDLE);
    assign w_mem = ex_isLd | ex_isSt;
`ifdef MA_MISALIGN_TRAP_EN
    assign w_mis = w_mem & (ex_aluResult[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    // Counter holds cycles already spent waiting, so T-1 marks the last allowed cycle
    assign w_to = (r_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) r_state <= MA_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == MA_IDLE) w_next = (w_acc && w_mem && !w_mis) ? MA_MEM_WAIT : MA_IDLE;
        else if (mem_ack || w_to) w_next = MA_IDLE;
    end

    always_comb begin
        ex_ready = r_alive && (r_state == MA_IDLE);
        mem_req  = (r_state == MA_MEM_WAIT);
        w_fire   = mem_req ? (mem_ack | w_to) : (w_acc & (~w_mem | w_mis));
        w_kill   = mem_req ? (~mem_ack & w_to) : (w_acc & w_mis);
        w_ld_we  = mem_req & mem_ack & ~r_we;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= w_kill;
            r_cnt   <= (r_state == MA_MEM_WAIT) ? r_cnt + CW'(1) : '0;
            if (w_acc && w_mem) begin
                r_we    <= ex_isSt & ~ex_isLd;
                r_addr  <= {ex_aluResult[31:2], 2'b00};
                r_wdata <= ex_op2;
            end
        end
    end

    assign w_fields = '{isWb: ex_isWb, isCall: ex_isCall, isLd: ex_isLd, Rd: ex_Rd,
                        aluResult: ex_aluResult, ldResult: {DATA_W{1'b0}}, pc: ex_pc};

    ma_rw_latch u_latch (
        .i_clk     (Clk),
        .i_rst_n   (reset),
        .i_load    (w_acc),
        .i_fields  (w_fields),
        .i_ld_we   (w_ld_we),
        .i_ld_data (mem_rdata),
        .i_fire    (w_fire),
        .i_kill_wb (w_kill),
        .o_valid   (rw_valid),
        .o_bundle  (w_bundle)
    );

    assign isWb       = w_bundle.isWb;
    assign isCall     = w_bundle.isCall;
    assign isLd       = w_bundle.isLd;
    assign Rd         = w_bundle.Rd;
    assign aluResult  = w_bundle.aluResult;
    assign ldResult   = w_bundle.ldResult;
    assign pc_current = w_bundle.pc;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_err    = r_err;
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: directed self-checking bench for ma_stage built with MEM_TIMEOUT=4
module tb_ma_stage;
    logic        Clk = 1'b0, reset = 1'b0;
    logic        ex_valid = 1'b0, ex_isLd = 1'b0, ex_isSt = 1'b0, ex_isWb = 1'b0, ex_isCall = 1'b0;
    logic [3:0]  ex_Rd = '0;
    logic [31:0] ex_aluResult = '0, ex_op2 = '0, ex_pc = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        ex_ready, mem_req, mem_we, isWb, isCall, isLd, rw_valid, mem_err;
    logic [31:0] mem_addr, mem_wdata, aluResult, ldResult, pc_current;
    logic [3:0]  Rd;
    int          n_cmp = 0, n_bad = 0;

    always #5 Clk = ~Clk;

    ma_stage #(.MEM_TIMEOUT(4)) dut (
        .Clk(Clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_isLd(ex_isLd), .ex_isSt(ex_isSt), .ex_isWb(ex_isWb), .ex_isCall(ex_isCall),
        .ex_Rd(ex_Rd), .ex_aluResult(ex_aluResult), .ex_op2(ex_op2), .ex_pc(ex_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .isWb(isWb), .isCall(isCall), .isLd(isLd),
        .Rd(Rd), .aluResult(aluResult), .ldResult(ldResult), .pc_current(pc_current),
        .rw_valid(rw_valid), .mem_err(mem_err)
    );

    task automatic tick;
        @(posedge Clk); #1;
    endtask

    task automatic clear_ex;
        ex_valid = 0; ex_isLd = 0; ex_isSt = 0; ex_isWb = 0; ex_isCall = 0;
        ex_Rd = '0; ex_aluResult = '0; ex_op2 = '0; ex_pc = '0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ex_ready: got %b want 0", ex_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rw_valid: got %b want 0", rw_valid); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        n_cmp++; if (aluResult !== 32'h0) begin n_bad++; $display("FAIL rst_aluResult: got %h want 0", aluResult); end
        @(negedge Clk) reset = 1;
        tick;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", ex_ready); end
    endtask

    task automatic test_alu;
        ex_valid = 1; ex_isWb = 1; ex_Rd = 4'd1; ex_aluResult = 32'hDEADBEEF;
        tick; clear_ex;
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL alu_rw_valid: got %b want 1", rw_valid); end
        n_cmp++; if (isWb !== 1'b1) begin n_bad++; $display("FAIL alu_isWb: got %b want 1", isWb); end
        n_cmp++; if (Rd !== 4'd1) begin n_bad++; $display("FAIL alu_Rd: got %h want 1", Rd); end
        n_cmp++; if (aluResult !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_aluResult: got %h want deadbeef", aluResult); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL alu_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ex_ready: got %b want 1", ex_ready); end
    endtask

    task automatic test_load;
        ex_valid = 1; ex_isLd = 1; ex_isWb = 1; ex_Rd = 4'd3; ex_aluResult = 32'h100;
        tick; clear_ex;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL ld_mem_req[%0d]: got %b want 1", i, mem_req); end
            n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL ld_mem_addr[%0d]: got %h want 100", i, mem_addr); end
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ld_mem_we[%0d]: got %b want 0", i, mem_we); end
            n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL ld_ex_ready[%0d]: got %b want 0", i, ex_ready); end
            n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL ld_early_rw[%0d]: got %b want 0", i, rw_valid); end
            if (i == 2) begin mem_ack = 1; mem_rdata = 32'hBEEFCAFE; end
            tick;
        end
        mem_ack = 0;
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL ld_rw_valid: got %b want 1", rw_valid); end
        n_cmp++; if (isLd !== 1'b1) begin n_bad++; $display("FAIL ld_isLd: got %b want 1", isLd); end
        n_cmp++; if (ldResult !== 32'hBEEFCAFE) begin n_bad++; $display("FAIL ld_ldResult: got %h want beefcafe", ldResult); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL ld_req_drop: got %b want 0", mem_req); end
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready_back: got %b want 1", ex_ready); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL ld_mem_err: got %b want 0", mem_err); end
    endtask

    task automatic test_store;
        ex_valid = 1; ex_isSt = 1; ex_aluResult = 32'h200; ex_op2 = 32'h12345678;
        tick; clear_ex;
        mem_ack = 1;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL st_mem_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL st_mem_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL st_wdata: got %h want 12345678", mem_wdata); end
        n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL st_addr: got %h want 200", mem_addr); end
        tick; mem_ack = 0;
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL st_rw_valid: got %b want 1", rw_valid); end
        n_cmp++; if (isWb !== 1'b0) begin n_bad++; $display("FAIL st_isWb: got %b want 0", isWb); end
        n_cmp++; if (ldResult !== 32'hBEEFCAFE) begin n_bad++; $display("FAIL st_ldResult_kept: got %h want beefcafe", ldResult); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL st_req_drop: got %b want 0", mem_req); end
    endtask

    task automatic test_back_to_back;
        ex_valid = 1; ex_isCall = 1; ex_isWb = 1; ex_Rd = 4'd15; ex_aluResult = 32'h4; ex_pc = 32'h1000;
        tick;
        ex_isCall = 0; ex_Rd = 4'd2; ex_aluResult = 32'h5; ex_pc = 32'h1004;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", ex_ready); end
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rw0: got %b want 1", rw_valid); end
        n_cmp++; if (isCall !== 1'b1) begin n_bad++; $display("FAIL b2b_isCall0: got %b want 1", isCall); end
        n_cmp++; if (pc_current !== 32'h1000) begin n_bad++; $display("FAIL b2b_pc0: got %h want 1000", pc_current); end
        tick; clear_ex;
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rw1: got %b want 1", rw_valid); end
        n_cmp++; if (isCall !== 1'b0) begin n_bad++; $display("FAIL b2b_isCall1: got %b want 0", isCall); end
        n_cmp++; if (aluResult !== 32'h5) begin n_bad++; $display("FAIL b2b_alu1: got %h want 5", aluResult); end
        tick;
        n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rw2: got %b want 0", rw_valid); end
        n_cmp++; if (isWb !== 1'b0) begin n_bad++; $display("FAIL b2b_isWb_gated: got %b want 0", isWb); end
    endtask

    task automatic test_timeout;
        ex_valid = 1; ex_isLd = 1; ex_isWb = 1; ex_aluResult = 32'h300;
        tick; clear_ex;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL to_req[%0d]: got %b want 1", i, mem_req); end
            n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL to_err_early[%0d]: got %b want 0", i, mem_err); end
            tick;
        end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL to_req_drop: got %b want 0", mem_req); end
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL to_rw_valid: got %b want 1", rw_valid); end
        n_cmp++; if (isWb !== 1'b0) begin n_bad++; $display("FAIL to_isWb: got %b want 0", isWb); end
        n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL to_mem_err: got %b want 1", mem_err); end
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b want 1", ex_ready); end
        tick;
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", mem_err); end
        n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL to_rw_pulse: got %b want 0", rw_valid); end
        ex_valid = 1; ex_isLd = 1; ex_isWb = 1; ex_aluResult = 32'h304;
        tick; clear_ex;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ack = 1; mem_rdata = 32'hA5A50F0F; end
            tick;
        end
        mem_ack = 0;
        n_cmp++; if (rw_valid !== 1'b1) begin n_bad++; $display("FAIL tack_rw_valid: got %b want 1", rw_valid); end
        n_cmp++; if (isWb !== 1'b1) begin n_bad++; $display("FAIL tack_isWb: got %b want 1", isWb); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL tack_mem_err: got %b want 0", mem_err); end
        n_cmp++; if (ldResult !== 32'hA5A50F0F) begin n_bad++; $display("FAIL tack_ldResult: got %h want a5a50f0f", ldResult); end
    endtask

    task automatic test_idle_ack_and_ld_st;
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick; mem_ack = 0;
        n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL iack_rw_valid: got %b want 0", rw_valid); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL iack_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (ldResult !== 32'hA5A50F0F) begin n_bad++; $display("FAIL iack_ldResult: got %h want a5a50f0f", ldResult); end
        ex_valid = 1; ex_isLd = 1; ex_isSt = 1; ex_aluResult = 32'h103; ex_op2 = 32'h77;
        tick; clear_ex;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ldst_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL ldst_addr: got %h want 100", mem_addr); end
        mem_ack = 1; mem_rdata = 32'h11;
        tick; mem_ack = 0;
        n_cmp++; if (isLd !== 1'b1) begin n_bad++; $display("FAIL ldst_isLd: got %b want 1", isLd); end
        n_cmp++; if (ldResult !== 32'h11) begin n_bad++; $display("FAIL ldst_ldResult: got %h want 11", ldResult); end
        n_cmp++; if (aluResult !== 32'h103) begin n_bad++; $display("FAIL ldst_alu: got %h want 103", aluResult); end
    endtask

    task automatic test_reset_mid;
        ex_valid = 1; ex_isLd = 1; ex_isWb = 1; ex_aluResult = 32'h400;
        tick; clear_ex;
        tick;
        reset = 0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req: got %b want 0", mem_req); end
        n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready: got %b want 0", ex_ready); end
        for (int i = 0; i < 2; i++) begin
            tick;
            n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rw[%0d]: got %b want 0", i, rw_valid); end
        end
        @(negedge Clk) reset = 1;
        tick;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after: got %b want 1", ex_ready); end
        n_cmp++; if (rw_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rw_after: got %b want 0", rw_valid); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req_after: got %b want 0", mem_req); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_back_to_back;
        test_timeout;
        test_idle_ack_and_ld_st;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
